if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and issues word fetches to instruction memory over a req/ready handshake that tolerates wait states. It holds each fetched word in a one-entry output slot that IF/ID drains, and it honours hazard-unit stalls and branch/jump redirects resolved in ID. It produces the instruction, PC+4 and PC page (PC+4[31:28]) that IF/ID latches.

---
 rtl/if_fetch_unit_pkg.sv | 18 +
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, state encoding and PC helper for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam logic [31:0] WORD_ZERO        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Wraps modulo 2^32; low two bits pass through untouched.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ready handshake and one-entry output slot for IF/ID.
// Optional event tracing is compiled in when FETCH_TRACE_EN is defined.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus_4_out,
  output logic [3:0]  pc_page_out,
  output logic        fetch_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= WORD_ZERO;
      inst_q  <= WORD_ZERO;
      pc4_q   <= WORD_ZERO;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    imem_req  = 1'b1;
    imem_addr = addr_q;
    fill      = 1'b0;

    if (pc_write) valid_d = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        // Only fetch when the slot is empty or being drained this edge.
        imem_req  = !valid_q | pc_write;
        imem_addr = pc_q;
        if (imem_req) addr_d = pc_q;
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_target;
          if (imem_req && !imem_ready) state_d = FETCH_DROP;
        end else if (imem_req) begin
          if (imem_ready) fill = 1'b1;
          else            state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_target;
          state_d = imem_ready ? FETCH_REQ : FETCH_DROP;
        end else if (imem_ready) begin
          fill    = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (redirect)   pc_d    = redirect_target;
        if (imem_ready) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase

    if (fill) begin
      inst_d  = imem_rdata;
      pc4_d   = pc_next(pc_q);
      pc_d    = pc_next(pc_q);
      valid_d = 1'b1;
    end
  end

  // An empty slot presents an all-zero NOP to IF/ID.
  assign fetch_valid     = valid_q;
  assign instruction_out = valid_q ? inst_q : WORD_ZERO;
  assign pc_plus_4_out   = valid_q ? pc4_q  : WORD_ZERO;
  assign pc_page_out     = valid_q ? pc4_q[31:28] : 4'b0000;

`ifdef FETCH_TRACE_EN
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      $display("@%t: IF_FETCH::RESET", $time);
    end else begin
      if (fill)     $display("@%t: IF_FETCH::FILL", $time);
      if (redirect) $display("@%t: IF_FETCH::REDIRECT", $time);
      if (state_d == FETCH_DROP && state_q != FETCH_DROP)
        $display("@%t: IF_FETCH::DROP", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, zero-wait streaming, wait states, stall, redirect, wrap, reset in WAIT.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] K   = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus_4_out;
  logic [3:0]  pc_page_out;
  logic        fetch_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address it was asked for.
  assign imem_rdata = imem_addr ^ K;

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction_out(instruction_out),
    .pc_plus_4_out(pc_plus_4_out), .pc_page_out(pc_page_out), .fetch_valid(fetch_valid)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; pc_write = 1'b0; redirect = 1'b0; redirect_target = 32'h0; imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; pc_write = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
    #1;
    total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=%h", instruction_out, 32'h0); end
    total++; if (pc_plus_4_out !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus_4_out, 32'h0); end
    total++; if (pc_page_out !== 4'h0) begin bad++; $display("FAIL reset_page got=%h exp=%h", pc_page_out, 4'h0); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_rel_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL reset_rel_addr got=%h exp=%h", imem_addr, RPC); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ea [4];
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    apply_reset();
    pc_write = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (imem_addr !== ea[i]) begin bad++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem_addr, ea[i]); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req[%0d] got=%b exp=1", i, imem_req); end
      if (i == 0) begin
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL zw_valid0 got=%b exp=0", fetch_valid); end
      end else begin
        total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, fetch_valid); end
        total++; if (instruction_out !== (ea[i-1] ^ K)) begin bad++; $display("FAIL zw_inst[%0d] got=%h exp=%h", i, instruction_out, ea[i-1] ^ K); end
        total++; if (pc_plus_4_out !== ea[i]) begin bad++; $display("FAIL zw_pc4[%0d] got=%h exp=%h", i, pc_plus_4_out, ea[i]); end
      end
      step();
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    apply_reset();
    pc_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ready = (i == 2);
      #1;
      total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL ws_addr[%0d] got=%h exp=%h", i, imem_addr, 32'h100); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL ws_req[%0d] got=%b exp=1", i, imem_req); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL ws_valid[%0d] got=%b exp=0", i, fetch_valid); end
      total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL ws_nop[%0d] got=%h exp=0", i, instruction_out); end
      step();
    end
    imem_ready = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL ws_fill_valid got=%b exp=1", fetch_valid); end
    total++; if (instruction_out !== (32'h100 ^ K)) begin bad++; $display("FAIL ws_fill_inst got=%h exp=%h", instruction_out, 32'h100 ^ K); end
    total++; if (pc_plus_4_out !== 32'h104) begin bad++; $display("FAIL ws_fill_pc4 got=%h exp=%h", pc_plus_4_out, 32'h104); end
    total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL ws_next_addr got=%h exp=%h", imem_addr, 32'h104); end
  endtask

  task automatic test_stall();
    apply_reset();
    pc_write = 1'b1; imem_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      pc_write = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_req[%0d] got=%b exp=0", i, imem_req); end
      total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, imem_addr, 32'h104); end
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL st_valid[%0d] got=%b exp=1", i, fetch_valid); end
      total++; if (instruction_out !== (32'h100 ^ K)) begin bad++; $display("FAIL st_inst[%0d] got=%h exp=%h", i, instruction_out, 32'h100 ^ K); end
      total++; if (pc_plus_4_out !== 32'h104) begin bad++; $display("FAIL st_pc4[%0d] got=%h exp=%h", i, pc_plus_4_out, 32'h104); end
      step();
    end
    pc_write = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL st_resume_req got=%b exp=1", imem_req); end
    step();
    imem_ready = 1'b0;
    #1;
    total++; if (instruction_out !== (32'h104 ^ K)) begin bad++; $display("FAIL st_resume_inst got=%h exp=%h", instruction_out, 32'h104 ^ K); end
    total++; if (pc_plus_4_out !== 32'h108) begin bad++; $display("FAIL st_resume_pc4 got=%h exp=%h", pc_plus_4_out, 32'h108); end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] ea [6];
    logic        rd [6];
    logic        rdy [6];
    ea  = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h2000, 32'h2000};
    rd  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    pc_write = 1'b1; redirect_target = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      redirect = rd[i]; imem_ready = rdy[i];
      #1;
      total++; if (imem_addr !== ea[i]) begin bad++; $display("FAIL rw_addr[%0d] got=%h exp=%h", i, imem_addr, ea[i]); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rw_valid[%0d] got=%b exp=0", i, fetch_valid); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rw_req[%0d] got=%b exp=1", i, imem_req); end
      step();
    end
    redirect = 1'b0; imem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    logic [3:0]  ep [4];
    ea = '{32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    ep = '{4'h0, 4'h0, 4'hF, 4'h0};
    apply_reset();
    pc_write = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      redirect = (i == 0); redirect_target = 32'hFFFF_FFF8;
      #1;
      total++; if (imem_addr !== ea[i]) begin bad++; $display("FAIL wr_addr[%0d] got=%h exp=%h", i, imem_addr, ea[i]); end
      total++; if (fetch_valid !== (i >= 2)) begin bad++; $display("FAIL wr_valid[%0d] got=%b exp=%b", i, fetch_valid, (i >= 2)); end
      total++; if (pc_page_out !== ep[i]) begin bad++; $display("FAIL wr_page[%0d] got=%h exp=%h", i, pc_page_out, ep[i]); end
      if (i >= 2) begin
        total++; if (pc_plus_4_out !== ea[i]) begin bad++; $display("FAIL wr_pc4[%0d] got=%h exp=%h", i, pc_plus_4_out, ea[i]); end
        total++; if (instruction_out !== (ea[i-1] ^ K)) begin bad++; $display("FAIL wr_inst[%0d] got=%h exp=%h", i, instruction_out, ea[i-1] ^ K); end
      end
      step();
    end
    redirect = 1'b0; imem_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    pc_write = 1'b1; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL rw_pre_valid got=%b exp=1", fetch_valid); end
    step();
    #1;
    total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL riw_wait_addr got=%h exp=%h", imem_addr, 32'h104); end
    rst = 1'b0;
    #1;
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL riw_rst_addr got=%h exp=%h", imem_addr, RPC); end
    total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL riw_rst_inst got=%h exp=0", instruction_out); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL riw_rst_valid got=%b exp=0", fetch_valid); end
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL riw_rel_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL riw_rel_addr got=%h exp=%h", imem_addr, RPC); end
    step();
    imem_ready = 1'b0;
    #1;
    total++; if (instruction_out !== (RPC ^ K)) begin bad++; $display("FAIL riw_refill_inst got=%h exp=%h", instruction_out, RPC ^ K); end
    total++; if (pc_plus_4_out !== 32'h104) begin bad++; $display("FAIL riw_refill_pc4 got=%h exp=%h", pc_plus_4_out, 32'h104); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_wait();
    test_wrap();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
